// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM state codes and
// the pattern returned to a port whose access is aborted.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_D = 3'd1,
    ARB_BUSY_I = 3'd2,
    ARB_DONE_D = 3'd3,
    ARB_DONE_I = 3'd4
  } arb_state_t;

  localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and MEM data port onto one single-ported memory.
// Optional macro ARB_TIMEOUT_EN adds an ack timeout with a sticky arb_err flag.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ARB_IDLE   | no access in flight
// ARB_BUSY_D | data access issued, waiting for ram_ack
// ARB_BUSY_I | fetch issued, waiting for ram_ack
// ARB_DONE_D | mem_din valid; data_stall low for this one cycle
// ARB_DONE_I | inst_data valid; inst_stall low for this one cycle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_stall,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              data_stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              arb_err
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_t state, state_nxt;
  logic       dreq;
  logic       busy;
  logic       load_d;
  logic       load_i;
  logic       finish;
  logic       abort;

  assign dreq       = mem_ren | mem_wen;
  assign busy       = (state == ARB_BUSY_D) || (state == ARB_BUSY_I);
  assign inst_stall = inst_ren & (state != ARB_DONE_I);
  assign data_stall = dreq & (state != ARB_DONE_D);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] tmo_cnt;

  // ram_ack wins over a timeout landing in the same cycle
  assign abort = busy & ~ram_ack & (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      arb_err <= 1'b0;
    end else begin
      if (load_d || load_i) begin
        tmo_cnt <= '0;
      end else if (busy && !ram_ack) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (abort) begin
        arb_err <= 1'b1;
      end
    end
  end
`else
  assign abort   = 1'b0;
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_d    = 1'b0;
    load_i    = 1'b0;
    finish    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (dreq) begin
          state_nxt = ARB_BUSY_D;
          load_d    = 1'b1;
        end else if (inst_ren) begin
          state_nxt = ARB_BUSY_I;
          load_i    = 1'b1;
        end
      end
      ARB_BUSY_D: begin
        if (ram_ack || abort) begin
          state_nxt = ARB_DONE_D;
          finish    = 1'b1;
        end
      end
      ARB_BUSY_I: begin
        if (ram_ack || abort) begin
          state_nxt = ARB_DONE_I;
          finish    = 1'b1;
        end
      end
      ARB_DONE_D: begin
        if (inst_ren) begin
          state_nxt = ARB_BUSY_I;
          load_i    = 1'b1;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_DONE_I: begin
        if (dreq) begin
          state_nxt = ARB_BUSY_D;
          load_d    = 1'b1;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // A read-and-write request from MEM goes out as a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (load_d) begin
      ram_req   <= 1'b1;
      ram_we    <= mem_wen;
      ram_addr  <= mem_addr;
      ram_wdata <= mem_dout;
    end else if (load_i) begin
      ram_req   <= 1'b1;
      ram_we    <= 1'b0;
      ram_addr  <= inst_addr;
      ram_wdata <= '0;
    end else if (finish) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din   <= '0;
      inst_data <= '0;
    end else if (finish) begin
      if (state == ARB_BUSY_D) begin
        mem_din <= abort ? DATA_W'(ARB_ABORT_DATA) : ram_rdata;
      end else begin
        inst_data <= abort ? DATA_W'(ARB_ABORT_DATA) : ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=8 so the
// ARB_TIMEOUT_EN build can be exercised in a few cycles).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          inst_ren;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_data;
  logic          inst_stall;
  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] mem_din;
  logic          data_stall;
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ack;
  logic          arb_err;

  int vectors = 0;
  int errors  = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_stall(inst_stall),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .data_stall(data_stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change 1ns after the rising edge; checks happen 4ns after it
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    settle();
    vectors++; if (ram_req !== 1'b0) begin errors++; $display("FAIL reset_ram_req got %h want 0", ram_req); end
    vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %h want 0", ram_we); end
    vectors++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
    vectors++; if (ram_wdata !== '0) begin errors++; $display("FAIL reset_ram_wdata got %h want 0", ram_wdata); end
    vectors++; if (inst_data !== '0) begin errors++; $display("FAIL reset_inst_data got %h want 0", inst_data); end
    vectors++; if (mem_din !== '0) begin errors++; $display("FAIL reset_mem_din got %h want 0", mem_din); end
    vectors++; if (arb_err !== 1'b0) begin errors++; $display("FAIL reset_arb_err got %h want 0", arb_err); end
    vectors++; if ({inst_stall, data_stall} !== 2'b00) begin errors++; $display("FAIL reset_stalls got %b want 00", {inst_stall, data_stall}); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    next_cycle();
    inst_ren = 1'b1; inst_addr = 32'h0000_0010;
    settle();
    vectors++; if (inst_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %h want 1", inst_stall); end
    vectors++; if (ram_req !== 1'b0) begin errors++; $display("FAIL fetch_req_c0 got %h want 0", ram_req); end
    next_cycle();
    ram_ack = 1'b1; ram_rdata = 32'h2010_0005;
    settle();
    vectors++; if (ram_req !== 1'b1) begin errors++; $display("FAIL fetch_req_c1 got %h want 1", ram_req); end
    vectors++; if (ram_addr !== 32'h0000_0010) begin errors++; $display("FAIL fetch_addr_c1 got %h want 00000010", ram_addr); end
    vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL fetch_we_c1 got %h want 0", ram_we); end
    vectors++; if (inst_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c1 got %h want 1", inst_stall); end
    next_cycle();
    ram_ack = 1'b0; ram_rdata = '0;
    settle();
    vectors++; if (inst_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_c2 got %h want 0", inst_stall); end
    vectors++; if (inst_data !== 32'h2010_0005) begin errors++; $display("FAIL fetch_data_c2 got %h want 20100005", inst_data); end
    vectors++; if (ram_req !== 1'b0) begin errors++; $display("FAIL fetch_req_c2 got %h want 0", ram_req); end
    next_cycle();
    inst_ren = 1'b0;
    settle();
    vectors++; if (ram_req !== 1'b0) begin errors++; $display("FAIL fetch_req_c3 got %h want 0", ram_req); end
    vectors++; if (inst_data !== 32'h2010_0005) begin errors++; $display("FAIL fetch_hold_c3 got %h want 20100005", inst_data); end
  endtask

  task automatic test_simultaneous();
    next_cycle();
    inst_ren = 1'b1; inst_addr = 32'h0000_0014;
    mem_ren = 1'b1; mem_addr = 32'h0000_0100;
    settle();
    vectors++; if ({inst_stall, data_stall} !== 2'b11) begin errors++; $display("FAIL sim_stalls_c0 got %b want 11", {inst_stall, data_stall}); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 3) begin ram_ack = 1'b1; ram_rdata = 32'h1111_2222; end
      settle();
      vectors++; if (ram_req !== 1'b1 || ram_addr !== 32'h0000_0100 || ram_we !== 1'b0) begin
        errors++; $display("FAIL sim_data_busy_c%0d got req=%h addr=%h we=%h want 1/00000100/0", c, ram_req, ram_addr, ram_we); end
      vectors++; if ({inst_stall, data_stall} !== 2'b11) begin errors++; $display("FAIL sim_stalls_c%0d got %b want 11", c, {inst_stall, data_stall}); end
    end
    next_cycle();
    ram_ack = 1'b0; ram_rdata = '0;
    settle();
    vectors++; if ({inst_stall, data_stall} !== 2'b10) begin errors++; $display("FAIL sim_stalls_c4 got %b want 10", {inst_stall, data_stall}); end
    vectors++; if (mem_din !== 32'h1111_2222) begin errors++; $display("FAIL sim_mem_din_c4 got %h want 11112222", mem_din); end
    vectors++; if (ram_req !== 1'b0) begin errors++; $display("FAIL sim_req_c4 got %h want 0", ram_req); end
    for (int c = 5; c <= 7; c++) begin
      next_cycle();
      mem_ren = 1'b0;
      if (c == 7) begin ram_ack = 1'b1; ram_rdata = 32'h3333_4444; end
      settle();
      vectors++; if (ram_req !== 1'b1 || ram_addr !== 32'h0000_0014) begin
        errors++; $display("FAIL sim_fetch_busy_c%0d got req=%h addr=%h want 1/00000014", c, ram_req, ram_addr); end
      vectors++; if ({inst_stall, data_stall} !== 2'b10) begin errors++; $display("FAIL sim_stalls_c%0d got %b want 10", c, {inst_stall, data_stall}); end
    end
    next_cycle();
    ram_ack = 1'b0; ram_rdata = '0;
    settle();
    vectors++; if (inst_stall !== 1'b0) begin errors++; $display("FAIL sim_istall_c8 got %h want 0", inst_stall); end
    vectors++; if (inst_data !== 32'h3333_4444) begin errors++; $display("FAIL sim_inst_data_c8 got %h want 33334444", inst_data); end
    vectors++; if (mem_din !== 32'h1111_2222) begin errors++; $display("FAIL sim_mem_din_hold_c8 got %h want 11112222", mem_din); end
    next_cycle();
    inst_ren = 1'b0;
  endtask

  task automatic test_store();
    next_cycle();
    mem_wen = 1'b1; mem_addr = 32'h0000_0200; mem_dout = 32'hCAFE_F00D;
    settle();
    vectors++; if (data_stall !== 1'b1) begin errors++; $display("FAIL store_stall_c0 got %h want 1", data_stall); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 3) begin ram_ack = 1'b1; ram_rdata = 32'h5555_5555; end
      settle();
      vectors++; if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 32'hCAFE_F00D || ram_addr !== 32'h0000_0200) begin
        errors++; $display("FAIL store_busy_c%0d got req=%h we=%h wdata=%h addr=%h want 1/1/cafef00d/00000200", c, ram_req, ram_we, ram_wdata, ram_addr); end
      vectors++; if (data_stall !== 1'b1) begin errors++; $display("FAIL store_stall_c%0d got %h want 1", c, data_stall); end
    end
    next_cycle();
    ram_ack = 1'b0; ram_rdata = '0;
    settle();
    vectors++; if (data_stall !== 1'b0) begin errors++; $display("FAIL store_stall_c4 got %h want 0", data_stall); end
    vectors++; if (ram_req !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL store_release_c4 got req=%h we=%h want 0/0", ram_req, ram_we); end
    next_cycle();
    mem_wen = 1'b0; mem_dout = '0;
  endtask

  task automatic test_read_write_both();
    next_cycle();
    mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h0000_0300; mem_dout = 32'h1234_5678;
    next_cycle();
    ram_ack = 1'b1;
    settle();
    vectors++; if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL both_write_c1 got req=%h we=%h wdata=%h want 1/1/12345678", ram_req, ram_we, ram_wdata); end
    next_cycle();
    ram_ack = 1'b0;
    settle();
    vectors++; if (data_stall !== 1'b0 || ram_req !== 1'b0) begin errors++; $display("FAIL both_done_c2 got stall=%h req=%h want 0/0", data_stall, ram_req); end
    next_cycle();
    mem_ren = 1'b0; mem_wen = 1'b0; mem_dout = '0;
    settle();
    vectors++; if (ram_req !== 1'b0) begin errors++; $display("FAIL both_single_c3 got %h want 0", ram_req); end
  endtask

  task automatic test_async_reset();
    next_cycle();
    mem_ren = 1'b1; mem_addr = 32'h0000_0400;
    next_cycle();
    settle();
    vectors++; if (ram_req !== 1'b1) begin errors++; $display("FAIL rst_busy_req got %h want 1", ram_req); end
    rst_n = 1'b0;
    #2;
    vectors++; if (ram_req !== 1'b0 || ram_addr !== '0 || mem_din !== '0) begin
      errors++; $display("FAIL rst_async got req=%h addr=%h din=%h want 0/0/0", ram_req, ram_addr, mem_din); end
    mem_ren = 1'b0;
    #1;
    rst_n = 1'b1;
    next_cycle();
    ram_ack = 1'b1; ram_rdata = 32'hBAD0_BAD0;
    settle();
    vectors++; if (ram_req !== 1'b0 || data_stall !== 1'b0) begin errors++; $display("FAIL rst_stray_ack got req=%h stall=%h want 0/0", ram_req, data_stall); end
    next_cycle();
    ram_ack = 1'b0; ram_rdata = '0;
    settle();
    vectors++; if (mem_din !== '0 || inst_data !== '0) begin errors++; $display("FAIL rst_stray_capture got din=%h idata=%h want 0/0", mem_din, inst_data); end
  endtask

  task automatic test_timeout();
    next_cycle();
    mem_ren = 1'b1; mem_addr = 32'h0000_0500;
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      settle();
      vectors++; if (data_stall !== 1'b1 || ram_req !== 1'b1 || arb_err !== 1'b0) begin
        errors++; $display("FAIL tmo_busy_c%0d got stall=%h req=%h err=%h want 1/1/0", c, data_stall, ram_req, arb_err); end
    end
    next_cycle();
    settle();
    vectors++; if (data_stall !== 1'b0) begin errors++; $display("FAIL tmo_stall_c9 got %h want 0", data_stall); end
    vectors++; if (mem_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tmo_din_c9 got %h want deadbeef", mem_din); end
    vectors++; if (arb_err !== 1'b1 || ram_req !== 1'b0) begin errors++; $display("FAIL tmo_err_c9 got err=%h req=%h want 1/0", arb_err, ram_req); end
    next_cycle();
    mem_ren = 1'b0;
    next_cycle();
    settle();
    vectors++; if (arb_err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got %h want 1", arb_err); end
`else
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      settle();
      vectors++; if (data_stall !== 1'b1 || ram_req !== 1'b1 || arb_err !== 1'b0) begin
        errors++; $display("FAIL notmo_busy_c%0d got stall=%h req=%h err=%h want 1/1/0", c, data_stall, ram_req, arb_err); end
    end
    rst_n = 1'b0;
    mem_ren = 1'b0;
    #2;
    rst_n = 1'b1;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    inst_ren = 1'b0; inst_addr = '0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
    ram_rdata = '0; ram_ack = 1'b0;
    #9;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_read_write_both();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
